rgmii_rx_packer: RTL and testbench

Parametrised successor to the byte-wide RGMII receive decoder. It takes the SDR-converted RGMII nibble pairs and control bits, strips the preamble and SFD, and packs frame bytes into `DATA_BYTES`-wide words with byte-keep, last and error qualifiers. It also keeps saturating frame and error statistics. It sits between the IDDR capture stage (rxClk domain) and the downstream MoldUDP64/ITCH parser.

---
 rtl/rgmii_pkg.sv | 14 +
 rtl/rgmii_crc32.sv | 22 ++
 rtl/rgmii_rx_packer.sv | 155 +++++++++++++++
 tb/tb_rgmii_rx_packer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// rgmii_pkg: shared states, framing constants and byte-serial CRC-32 step for the RGMII receive path
package rgmii_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC_POLY_REFL : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/rgmii_crc32.sv
// rgmii_crc32: byte-serial reflected CRC-32 with clear/enable and FCS residue match
module rgmii_crc32
  import rgmii_pkg::*;
(
  input  logic       rxClk,
  input  logic       rstLcl,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic       o_match
);
  logic [31:0] r_crc;
  logic [31:0] w_crc_rev;
  always_ff @(posedge rxClk or negedge rstLcl) begin
    if (!rstLcl) r_crc <= '1;
    else if (i_clr) r_crc <= '1;
    else if (i_en) r_crc <= crc32_byte(r_crc, i_data);
  end
  // residue constant is in MSB-first form, register is LSB-first
  assign w_crc_rev = {<<{r_crc}};
  assign o_match = w_crc_rev == CRC_RESIDUE;
endmodule

// File: rtl/rgmii_rx_packer.sv
// rgmii_rx_packer: strips preamble/SFD and packs RGMII bytes into keep/last/err words with stats
// RGMII_RX_FCS_CHECK_EN adds the CRC-32 FCS check on rxFcsErrOut
module rgmii_rx_packer
  import rgmii_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int MAX_PREAMBLE = 7,
  parameter int CNT_W = 16
) (
  input  logic                    rxClk,
  input  logic                    rstLcl,
  input  logic [7:0]              rxDataIn,
  input  logic [1:0]              rxCtrlIn,
  input  logic                    mmcmLockedIn,
  output logic [8*DATA_BYTES-1:0] rxDataOut,
  output logic [DATA_BYTES-1:0]   rxKeepOut,
  output logic                    rxDataValidOut,
  output logic                    rxDataLastOut,
  output logic                    rxErrOut,
  output logic                    rxFcsErrOut,
  output logic [CNT_W-1:0]        frameCntOut,
  output logic [CNT_W-1:0]        errCntOut
);
  localparam int W = 8 * DATA_BYTES;
  localparam int IDX_W = DATA_BYTES > 1 ? $clog2(DATA_BYTES) : 1;
  localparam int PC_W = $clog2(MAX_PREAMBLE + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  rx_state_t r_state, w_state_nxt;
  logic [PC_W-1:0] r_pcnt, w_pcnt_nxt;
  logic [W-1:0] r_acc, w_acc_nxt, r_cw, w_cw_nxt, w_lane, w_data;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic r_cw_vld, w_cw_vld_nxt, r_ferr, w_ferr_nxt;
  logic [DATA_BYTES-1:0] w_keep_part, w_keep;
  logic w_dv, w_er, w_sfd, w_wrap, w_fcs_bad;
  logic w_emit, w_last, w_bump_err, w_err_o, w_fcs_o, w_cnt_good, w_cnt_err;

  assign w_dv = rxCtrlIn[0];
  assign w_er = rxCtrlIn[0] ^ rxCtrlIn[1];
  assign w_sfd = w_dv && rxDataIn == SFD_BYTE;
  assign w_wrap = r_idx == LAST_IDX;
  assign w_lane = W'(rxDataIn) << (8 * r_idx);

  always_comb begin
    w_keep_part = '0;
    for (int i = 0; i < DATA_BYTES; i++) w_keep_part[i] = i < int'(r_idx);
  end

  always_ff @(posedge rxClk or negedge rstLcl) begin
    if (!rstLcl) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt = r_pcnt;
    w_acc_nxt = r_acc;
    w_idx_nxt = r_idx;
    w_cw_nxt = r_cw;
    w_cw_vld_nxt = 1'b0;
    w_ferr_nxt = r_ferr;
    w_emit = 1'b0;
    w_last = 1'b0;
    w_bump_err = 1'b0;
    case (r_state)
      IDLE: if (mmcmLockedIn && w_dv) begin
        w_state_nxt = rxDataIn == PREAMBLE_BYTE ? PREAMBLE : DROP;
        w_pcnt_nxt = PC_W'(1);
        w_bump_err = rxDataIn != PREAMBLE_BYTE;
      end
      PREAMBLE: if (!mmcmLockedIn || !w_dv) w_state_nxt = IDLE;
      else if (w_sfd) begin
        w_state_nxt = DATA;
        w_acc_nxt = '0;
        w_idx_nxt = '0;
        w_ferr_nxt = 1'b0;
      end else if (rxDataIn == PREAMBLE_BYTE && r_pcnt < PC_W'(MAX_PREAMBLE)) w_pcnt_nxt = r_pcnt + 1'b1;
      else begin
        w_state_nxt = DROP;
        w_bump_err = 1'b1;
      end
      // a completed word waits one cycle so dv can decide whether it is the last
      DATA: if (!mmcmLockedIn || !w_dv) begin
        w_state_nxt = IDLE;
        w_emit = r_cw_vld || r_idx != '0;
        w_last = w_emit;
        w_bump_err = !w_emit;
      end else begin
        w_emit = r_cw_vld;
        w_ferr_nxt = r_ferr | w_er;
        w_idx_nxt = w_wrap ? '0 : r_idx + 1'b1;
        w_acc_nxt = w_wrap ? '0 : r_acc | w_lane;
        w_cw_nxt = r_acc | w_lane;
        w_cw_vld_nxt = w_wrap;
      end
      default: if (!mmcmLockedIn || !w_dv) w_state_nxt = IDLE;
    endcase
  end

`ifdef RGMII_RX_FCS_CHECK_EN
  logic w_crc_ok;
  rgmii_crc32 u_crc (
    .rxClk   (rxClk),
    .rstLcl  (rstLcl),
    .i_clr   (r_state == PREAMBLE && w_sfd),
    .i_en    (r_state == DATA && mmcmLockedIn && w_dv),
    .i_data  (rxDataIn),
    .o_match (w_crc_ok)
  );
  assign w_fcs_bad = !w_crc_ok;
`else
  assign w_fcs_bad = 1'b0;
`endif

  assign w_data = r_cw_vld ? r_cw : r_acc;
  assign w_keep = r_cw_vld ? '1 : w_keep_part;
  assign w_err_o = w_last && (!mmcmLockedIn || r_ferr);
  assign w_fcs_o = w_last && w_fcs_bad;
  assign w_cnt_good = w_last && !w_err_o && !w_fcs_o;
  assign w_cnt_err = w_bump_err || (w_last && (w_err_o || w_fcs_o));

  always_ff @(posedge rxClk or negedge rstLcl) begin
    if (!rstLcl) begin
      r_pcnt <= '0;
      r_acc <= '0;
      r_idx <= '0;
      r_cw <= '0;
      r_cw_vld <= 1'b0;
      r_ferr <= 1'b0;
      rxDataOut <= '0;
      rxKeepOut <= '0;
      rxDataValidOut <= 1'b0;
      rxDataLastOut <= 1'b0;
      rxErrOut <= 1'b0;
      rxFcsErrOut <= 1'b0;
      frameCntOut <= '0;
      errCntOut <= '0;
    end else begin
      r_pcnt <= w_pcnt_nxt;
      r_acc <= w_acc_nxt;
      r_idx <= w_idx_nxt;
      r_cw <= w_cw_nxt;
      r_cw_vld <= w_cw_vld_nxt;
      r_ferr <= w_ferr_nxt;
      rxDataOut <= w_emit ? w_data : '0;
      rxKeepOut <= w_emit ? w_keep : '0;
      rxDataValidOut <= w_emit;
      rxDataLastOut <= w_last;
      rxErrOut <= w_err_o;
      rxFcsErrOut <= w_fcs_o;
      if (w_cnt_good && frameCntOut != '1) frameCntOut <= frameCntOut + 1'b1;
      if (w_cnt_err && errCntOut != '1) errCntOut <= errCntOut + 1'b1;
    end
  end
endmodule

// File: tb/tb_rgmii_rx_packer.sv
// tb_rgmii_rx_packer: directed frames with a word scoreboard checked by an independent monitor
module tb_rgmii_rx_packer;
`ifdef RGMII_RX_FCS_CHECK_EN
  localparam bit FCS_CHK = 1'b1;
`else
  localparam bit FCS_CHK = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        err;
    logic        fcs;
  } exp_t;

  logic rxClk = 1'b0;
  logic rstLcl = 1'b0;
  logic [7:0] rxDataIn = '0;
  logic [1:0] rxCtrlIn = '0;
  logic mmcmLockedIn = 1'b1;
  logic [31:0] rxDataOut;
  logic [3:0] rxKeepOut;
  logic rxDataValidOut, rxDataLastOut, rxErrOut, rxFcsErrOut;
  logic [15:0] frameCntOut, errCntOut;

  exp_t q[$];
  exp_t e;
  logic [7:0] fb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_f = 0;
  int exp_e = 0;

  rgmii_rx_packer #(.DATA_BYTES(4), .MAX_PREAMBLE(7), .CNT_W(16)) dut (
    .rxClk          (rxClk),
    .rstLcl         (rstLcl),
    .rxDataIn       (rxDataIn),
    .rxCtrlIn       (rxCtrlIn),
    .mmcmLockedIn   (mmcmLockedIn),
    .rxDataOut      (rxDataOut),
    .rxKeepOut      (rxKeepOut),
    .rxDataValidOut (rxDataValidOut),
    .rxDataLastOut  (rxDataLastOut),
    .rxErrOut       (rxErrOut),
    .rxFcsErrOut    (rxFcsErrOut),
    .frameCntOut    (frameCntOut),
    .errCntOut      (errCntOut)
  );

  always #5 rxClk = ~rxClk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge rxClk) begin
    if (rstLcl && rxDataValidOut) begin
      if (q.size() == 0) check("unexpected_valid", 64'(rxDataValidOut), 64'd0);
      else begin
        e = q.pop_front();
        check("word{data,keep,last,err,fcs}",
              64'({rxDataOut, rxKeepOut, rxDataLastOut, rxErrOut, rxFcsErrOut}), 64'(e));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge rxClk);
      rxDataIn = 8'h00;
      rxCtrlIn = 2'b00;
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic er);
    @(negedge rxClk);
    rxDataIn = b;
    rxCtrlIn = {1'b1 ^ er, 1'b1};
  endtask

  task automatic make(input int n, input bit inv);
    fb = {};
    for (int i = 0; i < n; i++) fb.push_back(inv ? 8'(255 - i) : 8'(i));
  endtask

  task automatic add_fcs();
    logic [31:0] c = '1;
    foreach (fb[i]) begin
      c ^= {24'h0, fb[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    c = ~c;
    for (int k = 0; k < 4; k++) fb.push_back(c[8*k+:8]);
  endtask

  function automatic exp_t mk(input int w, input bit last, input bit err, input bit fcs);
    exp_t x = '0;
    for (int j = 0; j < 4; j++)
      if (4 * w + j < fb.size()) begin
        x.data[8*j+:8] = fb[4*w+j];
        x.keep[j] = 1'b1;
      end
    x.last = last;
    x.err = err;
    x.fcs = fcs;
    return x;
  endfunction

  task automatic push_frame(input int er_at, input bit fcs_ok);
    int nw = (fb.size() + 3) / 4;
    bit err = er_at >= 0;
    bit fcs = FCS_CHK && !fcs_ok;
    if (nw == 0) begin
      exp_e++;
      return;
    end
    for (int w = 0; w < nw; w++) q.push_back(mk(w, w == nw - 1, err && w == nw - 1, fcs && w == nw - 1));
    if (err || fcs) exp_e++;
    else exp_f++;
  endtask

  task automatic send(input int npre, input int er_at, input int rst_at);
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    foreach (fb[i]) begin
      if (i == rst_at) begin
        @(negedge rxClk);
        rstLcl = 1'b0;
        rxCtrlIn = 2'b00;
        return;
      end
      drive(fb[i], i == er_at);
    end
    idle(1);
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_frameCnt"}, 64'(frameCntOut), 64'(exp_f));
    check({tag, "_errCnt"}, 64'(errCntOut), 64'(exp_e));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d words still expected", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge rxClk);
    check("reset_valid", 64'(rxDataValidOut), 64'd0);
    check("reset_data", 64'({rxDataOut, rxKeepOut, rxDataLastOut, rxErrOut, rxFcsErrOut}), 64'd0);
    check_cnts("reset");
    rstLcl = 1'b1;
    idle(2);
    make(1440, 1'b0);
    push_frame(-1, 1'b0);
    send(7, -1, -1);
    idle(3);
    check_cnts("frame1440");
    make(1441, 1'b0);
    push_frame(-1, 1'b0);
    send(7, -1, -1);
    idle(3);
    check_cnts("frame1441");
    drive(8'h55, 1'b0);
    drive(8'h5D, 1'b0);
    for (int i = 0; i < 6; i++) drive(8'(i), 1'b0);
    idle(2);
    exp_e++;
    check_cnts("bad_preamble");
    make(64, 1'b1);
    push_frame(-1, 1'b0);
    send(7, -1, -1);
    idle(3);
    check_cnts("after_bad_preamble");
    make(200, 1'b0);
    push_frame(100, 1'b0);
    send(7, 100, -1);
    idle(3);
    check_cnts("er_frame");
    fb = {};
    push_frame(-1, 1'b0);
    send(7, -1, -1);
    idle(2);
    check_cnts("zero_len");
    make(4, 1'b0);
    send(8, -1, -1);
    idle(2);
    exp_e++;
    check_cnts("long_preamble");
    make(6, 1'b0);
    push_frame(-1, 1'b0);
    send(7, -1, -1);
    make(7, 1'b1);
    push_frame(-1, 1'b0);
    send(3, -1, -1);
    idle(3);
    check_cnts("back_to_back");
    make(1440, 1'b0);
    for (int w = 0; w < 124; w++) q.push_back(mk(w, 1'b0, 1'b0, 1'b0));
    send(7, -1, 500);
    #1;
    check("rst_mid_valid", 64'({rxDataValidOut, rxDataLastOut}), 64'd0);
    exp_f = 0;
    exp_e = 0;
    check_cnts("rst_mid");
    repeat (2) @(negedge rxClk);
    rstLcl = 1'b1;
    check("rst_mid_drained", 64'(q.size()), 64'd0);
    idle(2);
    make(64, 1'b0);
    push_frame(-1, 1'b0);
    send(7, -1, -1);
    idle(3);
    check_cnts("after_reset");
    make(60, 1'b1);
    add_fcs();
    push_frame(-1, 1'b1);
    send(7, -1, -1);
    idle(3);
    check_cnts("fcs_good");
    fb[10] ^= 8'h04;
    push_frame(-1, 1'b0);
    send(7, -1, -1);
    idle(5);
    check_cnts("fcs_bad");
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
